// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register of the five-stage core.
//
// Captures the decoded instruction and forwarded operands from ID and presents
// them to EX one cycle later. Pipeline control:
//   - flush    : load a bubble (all ex_* zero), highest priority
//   - stall_ex : hold every ex_* field
//   - stall_id or a load-use hazard : load a bubble
//   - otherwise: capture id_* into ex_*
// A saturating counter records every bubble caused by a load-use hazard.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   flush               : flush request, forces a bubble
//   stall_id, stall_ex  : controller stall requests for ID and EX
//   load_related_1/2    : per-operand load-use hazard flags from ID
//   id_*                : decoded instruction fields from ID
//   load_stall_req      : combinational OR of the two hazard flags
//   ex_*                : registered instruction fields for EX
//   ex_load_flag        : registered load flag, returned to ID hazard logic
//   bubble_cnt          : saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_id,
    input  logic                      stall_ex,
    input  logic                      load_related_1,
    input  logic                      load_related_2,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [OP_WIDTH-1:0]       id_alu_op,
    input  logic [4:0]                id_shamt,
    input  logic [DATA_WIDTH-1:0]     id_operand_1,
    input  logic [DATA_WIDTH-1:0]     id_operand_2,
    input  logic                      id_write_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] id_write_reg_addr,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic [DATA_WIDTH-1:0]     id_mem_write_data,
    output logic                      load_stall_req,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [OP_WIDTH-1:0]       ex_alu_op,
    output logic [4:0]                ex_shamt,
    output logic [DATA_WIDTH-1:0]     ex_operand_1,
    output logic [DATA_WIDTH-1:0]     ex_operand_2,
    output logic                      ex_write_reg_en,
    output logic [REG_ADDR_WIDTH-1:0] ex_write_reg_addr,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [DATA_WIDTH-1:0]     ex_mem_write_data,
    output logic                      ex_load_flag,
    output logic [CNT_WIDTH-1:0]      bubble_cnt
);

    // Saturating increment: stays at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        else
            return v + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0]     pc_p1;
    logic [OP_WIDTH-1:0]       alu_op_p1;
    logic [4:0]                shamt_p1;
    logic [DATA_WIDTH-1:0]     operand_1_p1;
    logic [DATA_WIDTH-1:0]     operand_2_p1;
    logic                      write_reg_en_p1;
    logic [REG_ADDR_WIDTH-1:0] write_reg_addr_p1;
    logic                      mem_read_p1;
    logic                      mem_write_p1;
    logic [DATA_WIDTH-1:0]     mem_write_data_p1;
    logic [CNT_WIDTH-1:0]      bubble_cnt_p1;

    logic id_bubble;

    // Independent of rst so the controller can hold PC/IF/ID without delay.
    assign load_stall_req = load_related_1 | load_related_2;
    assign id_bubble      = stall_id | load_stall_req;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk) begin
        if (!rst || flush || (!stall_ex && id_bubble)) begin
            pc_p1             <= '0;
            alu_op_p1         <= '0;
            shamt_p1          <= '0;
            operand_1_p1      <= '0;
            operand_2_p1      <= '0;
            write_reg_en_p1   <= 1'b0;
            write_reg_addr_p1 <= '0;
            mem_read_p1       <= 1'b0;
            mem_write_p1      <= 1'b0;
            mem_write_data_p1 <= '0;
        end else if (stall_ex) begin
            pc_p1             <= pc_p1;
            alu_op_p1         <= alu_op_p1;
            shamt_p1          <= shamt_p1;
            operand_1_p1      <= operand_1_p1;
            operand_2_p1      <= operand_2_p1;
            write_reg_en_p1   <= write_reg_en_p1;
            write_reg_addr_p1 <= write_reg_addr_p1;
            mem_read_p1       <= mem_read_p1;
            mem_write_p1      <= mem_write_p1;
            mem_write_data_p1 <= mem_write_data_p1;
        end else begin
            pc_p1             <= id_pc;
            alu_op_p1         <= id_alu_op;
            shamt_p1          <= id_shamt;
            operand_1_p1      <= id_operand_1;
            operand_2_p1      <= id_operand_2;
            write_reg_en_p1   <= id_write_reg_en;
            write_reg_addr_p1 <= id_write_reg_addr;
            mem_read_p1       <= id_mem_read;
            mem_write_p1      <= id_mem_write;
            mem_write_data_p1 <= id_mem_write_data;
        end
    end

    // Only bubbles that actually come from the hazard path count; a flush or
    // an EX hold pre-empts the bubble, so nothing is counted then.
    always_ff @(posedge clk) begin
        if (!rst)
            bubble_cnt_p1 <= '0;
        else if (!flush && !stall_ex && load_stall_req)
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end

    assign ex_pc             = pc_p1;
    assign ex_alu_op         = alu_op_p1;
    assign ex_shamt          = shamt_p1;
    assign ex_operand_1      = operand_1_p1;
    assign ex_operand_2      = operand_2_p1;
    assign ex_write_reg_en   = write_reg_en_p1;
    assign ex_write_reg_addr = write_reg_addr_p1;
    assign ex_mem_read       = mem_read_p1;
    assign ex_mem_write      = mem_write_p1;
    assign ex_mem_write_data = mem_write_data_p1;
    assign ex_load_flag      = mem_read_p1;
    assign bubble_cnt        = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, stall_id, stall_ex, load_related_1, load_related_2;
    logic [31:0] id_pc;
    logic [7:0]  id_alu_op;
    logic [4:0]  id_shamt;
    logic [31:0] id_operand_1, id_operand_2;
    logic        id_write_reg_en;
    logic [4:0]  id_write_reg_addr;
    logic        id_mem_read, id_mem_write;
    logic [31:0] id_mem_write_data;
    logic        load_stall_req;
    logic [31:0] ex_pc;
    logic [7:0]  ex_alu_op;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_operand_1, ex_operand_2;
    logic        ex_write_reg_en;
    logic [4:0]  ex_write_reg_addr;
    logic        ex_mem_read, ex_mem_write;
    logic [31:0] ex_mem_write_data;
    logic        ex_load_flag;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
        .load_related_1(load_related_1), .load_related_2(load_related_2),
        .id_pc(id_pc), .id_alu_op(id_alu_op), .id_shamt(id_shamt),
        .id_operand_1(id_operand_1), .id_operand_2(id_operand_2),
        .id_write_reg_en(id_write_reg_en), .id_write_reg_addr(id_write_reg_addr),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_write_data(id_mem_write_data),
        .load_stall_req(load_stall_req),
        .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt),
        .ex_operand_1(ex_operand_1), .ex_operand_2(ex_operand_2),
        .ex_write_reg_en(ex_write_reg_en), .ex_write_reg_addr(ex_write_reg_addr),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_write_data(ex_mem_write_data),
        .ex_load_flag(ex_load_flag), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX plus the count.
    typedef struct {
        logic [31:0] pc;
        logic [7:0]  alu_op;
        logic [4:0]  shamt;
        logic [31:0] op1, op2;
        logic        we;
        logic [4:0]  wa;
        logic        mr, mw;
        logic [31:0] wd;
    } instr_t;

    instr_t m_ex;
    int     m_cnt;

    function automatic instr_t nop_instr();
        instr_t n;
        n.pc = 0; n.alu_op = 0; n.shamt = 0; n.op1 = 0; n.op2 = 0;
        n.we = 0; n.wa = 0; n.mr = 0; n.mw = 0; n.wd = 0;
        return n;
    endfunction

    function automatic instr_t id_instr();
        instr_t n;
        n.pc = id_pc; n.alu_op = id_alu_op; n.shamt = id_shamt;
        n.op1 = id_operand_1; n.op2 = id_operand_2;
        n.we = id_write_reg_en; n.wa = id_write_reg_addr;
        n.mr = id_mem_read; n.mw = id_mem_write; n.wd = id_mem_write_data;
        return n;
    endfunction

    // Apply the update rules to the inputs present just before the edge.
    task automatic model_edge();
        bit hazard;
        hazard = load_related_1 || load_related_2;
        if (!rst) begin
            m_ex  = nop_instr();
            m_cnt = 0;
        end else if (flush) begin
            m_ex = nop_instr();
        end else if (stall_ex) begin
            // EX holds its instruction
        end else if (stall_id || hazard) begin
            m_ex = nop_instr();
            if (hazard && m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_ex = id_instr();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    ex_pc,                     m_ex.pc);
        check({tag, ".aluop"}, {24'd0, ex_alu_op},        {24'd0, m_ex.alu_op});
        check({tag, ".shamt"}, {27'd0, ex_shamt},         {27'd0, m_ex.shamt});
        check({tag, ".op1"},   ex_operand_1,              m_ex.op1);
        check({tag, ".op2"},   ex_operand_2,              m_ex.op2);
        check({tag, ".we"},    {31'd0, ex_write_reg_en},  {31'd0, m_ex.we});
        check({tag, ".wa"},    {27'd0, ex_write_reg_addr},{27'd0, m_ex.wa});
        check({tag, ".mr"},    {31'd0, ex_mem_read},      {31'd0, m_ex.mr});
        check({tag, ".mw"},    {31'd0, ex_mem_write},     {31'd0, m_ex.mw});
        check({tag, ".wd"},    ex_mem_write_data,         m_ex.wd);
        check({tag, ".ldflag"},{31'd0, ex_load_flag},     {31'd0, m_ex.mr});
        check({tag, ".cnt"},   {16'd0, bubble_cnt},       m_cnt);
    endtask

    // One rising edge: update the model, then compare 1 time unit after it.
    task automatic tick(input string tag, input bit do_check);
        model_edge();
        @(posedge clk);
        #1;
        if (do_check) check_all(tag);
    endtask

    task automatic rand_id();
        id_pc             = $urandom;
        id_alu_op         = 8'($urandom);
        id_shamt          = 5'($urandom);
        id_operand_1      = $urandom;
        id_operand_2      = $urandom;
        id_write_reg_en   = 1'($urandom);
        id_write_reg_addr = 5'($urandom);
        id_mem_read       = 1'($urandom);
        id_mem_write      = 1'($urandom);
        id_mem_write_data = $urandom;
    endtask

    task automatic quiet_ctrl();
        flush = 0; stall_id = 0; stall_ex = 0; load_related_1 = 0; load_related_2 = 0;
    endtask

    initial begin
        m_ex = nop_instr();
        m_cnt = 0;
        quiet_ctrl();
        rand_id();

        // Reset with a recognisable operand waiting in ID
        rst = 0;
        id_operand_1 = 32'hDEADBEEF;
        tick("rst0", 1);
        tick("rst1", 1);
        check("rst_op1_zero", ex_operand_1, 32'h0);
        check("rst_cnt_zero", {16'd0, bubble_cnt}, 32'h0);
        load_related_2 = 1;
        #1;
        check("lsr_in_reset", {31'd0, load_stall_req}, 32'd1);
        load_related_2 = 0;
        #1;
        check("lsr_low", {31'd0, load_stall_req}, 32'd0);
        rst = 1;
        tick("rst_exit", 1);
        check("rst_exit_op1", ex_operand_1, 32'hDEADBEEF);

        // Plain capture
        rand_id();
        id_pc = 32'h00400010; id_write_reg_addr = 5; id_write_reg_en = 1;
        tick("cap", 1);
        check("cap_pc", ex_pc, 32'h00400010);
        check("cap_wa", {27'd0, ex_write_reg_addr}, 32'd5);
        check("cap_we", {31'd0, ex_write_reg_en}, 32'd1);

        // Load followed by a dependent instruction
        rand_id();
        id_mem_read = 1; id_write_reg_addr = 8; id_write_reg_en = 1;
        tick("ld", 1);
        check("ld_flag", {31'd0, ex_load_flag}, 32'd1);
        rand_id();
        id_write_reg_en = 1;
        load_related_1 = 1;
        #1;
        check("lu_req", {31'd0, load_stall_req}, 32'd1);
        tick("lu_bubble", 1);
        check("lu_we", {31'd0, ex_write_reg_en}, 32'd0);
        check("lu_flag", {31'd0, ex_load_flag}, 32'd0);
        check("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
        load_related_1 = 0;
        id_operand_1 = 32'hA5A5_0001;
        tick("lu_dep", 1);
        check("lu_dep_op1", ex_operand_1, 32'hA5A5_0001);

        // EX hold with changing ID contents
        rand_id();
        id_operand_2 = 32'h12345678;
        tick("hold_load", 1);
        stall_ex = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick("hold", 1);
            check("hold_op2", ex_operand_2, 32'h12345678);
        end
        stall_ex = 0;
        rand_id();
        id_operand_2 = 32'h0BADF00D;
        tick("hold_release", 1);
        check("release_op2", ex_operand_2, 32'h0BADF00D);

        // Flush beats stall_ex and the load hazard; counter stays put
        rand_id();
        id_write_reg_en = 1;
        flush = 1; stall_ex = 1; load_related_2 = 1;
        tick("flush_pri", 1);
        check("flush_we", {31'd0, ex_write_reg_en}, 32'd0);
        check("flush_cnt", {16'd0, bubble_cnt}, 32'd1);
        quiet_ctrl();

        // Reset while EX is stalled: leave reset holding a bubble
        rand_id();
        tick("pre_rst", 1);
        stall_ex = 1; rst = 0;
        tick("rst_stall", 1);
        rst = 1;
        tick("rst_stall_exit", 1);
        check("rst_stall_we", {31'd0, ex_write_reg_en}, 32'd0);
        quiet_ctrl();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rst            = ($urandom_range(0, 39) != 0);
            flush          = ($urandom_range(0, 9) == 0);
            stall_ex       = ($urandom_range(0, 5) == 0);
            stall_id       = ($urandom_range(0, 6) == 0);
            load_related_1 = ($urandom_range(0, 5) == 0);
            load_related_2 = ($urandom_range(0, 5) == 0);
            #1;
            check("rand_lsr", {31'd0, load_stall_req}, {31'd0, load_related_1 | load_related_2});
            tick("rand", 1);
        end

        // Saturation of the bubble counter
        quiet_ctrl();
        rst = 0;
        tick("sat_rst", 1);
        rst = 1;
        load_related_1 = 1;
        for (int i = 0; i < 65535; i++) begin
            rand_id();
            tick("sat", 0);
        end
        check("sat_full", {16'd0, bubble_cnt}, 32'h0000FFFF);
        tick("sat_plus1", 1);
        tick("sat_plus2", 1);
        check("sat_nowrap", {16'd0, bubble_cnt}, 32'h0000FFFF);
        load_related_1 = 0;
        tick("sat_after", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
